itch_tx: RTL and testbench
==========================

ITCH_TX -- requirements
Module: itch_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port hdr_valid  input  1  header offered.
REQ-004 SHALL have port hdr_ready  output  1  header accepted when hdr_valid & hdr_ready.
REQ-005 SHALL have port msg_type  input  8  ITCH type byte, sampled on header accept.
REQ-006 SHALL have port msg_len  input  16  frame body length (type byte + payload), sampled on header accept.
REQ-007 SHALL have port pl_data  input  8  payload byte.
REQ-008 SHALL have port pl_valid  input  1  payload byte offered.
REQ-009 SHALL have port pl_ready  output  1  payload byte taken when pl_valid & pl_ready.
REQ-010 SHALL have port tx_data  output  8  serialized byte, the same stream format itch_parser consumes.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid.
REQ-012 SHALL have port tx_ready  input  1  downstream accepts when tx_valid & tx_ready.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse when last byte of a frame is transferred.
REQ-014 SHALL have port len_err  output  1  one-cycle pulse on header rejection.
REQ-015 SHALL have port msg_count  output  32  frames fully transferred, wraps 0xFFFFFFFF->0.

Function
REQ-016 SHALL emit each frame as len[15:8], len[7:0], msg_type, then msg_len-1 payload bytes in arrival order.
REQ-017 SHALL use states IDLE, LEN_LO, TYPE, PAYLOAD, DRAIN; the len[15:8] byte is loaded on header accept.
REQ-018 SHALL hold tx_data/tx_valid in a single output register, loadable only when tx_valid==0 or tx_ready==1 ("slot free").
REQ-019 SHALL keep tx_data stable while tx_valid & !tx_ready.
REQ-020 SHALL drive hdr_ready = (state==IDLE) & slot free, combinationally.
REQ-021 SHALL present len[15:8] with tx_valid=1 the cycle after header accept (latency 1).
REQ-022 SHALL advance IDLE->LEN_LO->TYPE->PAYLOAD, one byte per free slot; TYPE->IDLE directly when msg_len==1.
REQ-023 SHALL drive pl_ready = (state==PAYLOAD) & slot free, loading pl_data into the register on acceptance.
REQ-024 SHALL count remaining payload with a 16-bit down-counter initialised to msg_len-1; return to IDLE when the last payload byte is loaded.
REQ-025 SHALL permit back-to-back frames: next len[15:8] may follow the previous last byte with zero idle cycles.
REQ-026 SHALL, on msg_len==0, accept the header, pulse len_err next cycle, emit nothing, stay IDLE, not increment msg_count.
REQ-027 SHALL pulse tx_done and increment msg_count in the cycle after the last byte of a frame transfers.
REQ-028 SHALL, in DRAIN, hold pl_ready=1, discard msg_len-1 payload bytes, keep tx_valid=0 for that frame, then return to IDLE (direct to IDLE if msg_len==1).
REQ-029 SHALL never assert hdr_ready and pl_ready in the same cycle.

Reset
REQ-030 SHALL, on rst low, immediately force state=IDLE, tx_valid=0, tx_data=0, tx_done=0, len_err=0, msg_count=0, payload counter=0, abandoning any partial frame.
REQ-031 SHALL hold hdr_ready=0 and pl_ready=0 while rst is low; hdr_ready=1 in the first cycle after release.

Configuration
REQ-032 SHALL, with ITCH_TX_LEN_CHECK_EN defined, check msg_len against ITCH 5.0 lengths: 'S'=12, 'R'=39, 'A'=36, 'F'=40, 'E'=31, 'C'=36, 'X'=23, 'D'=19, 'U'=35, 'P'=44; unknown types are unchecked.
REQ-033 SHALL, on mismatch with the macro defined, accept the header, pulse len_err next cycle, enter DRAIN, not count the frame.
REQ-034 SHALL, without the macro, send any msg_len>=1 unchecked; DRAIN is unreachable.

Verification
REQ-035 SHALL cover: type 'D', len 19, 18 payload bytes, tx_ready=1 -> 21 bytes 0x00,0x13,0x44,payload; tx_done once; msg_count=1.
REQ-036 SHALL cover: same frame, tx_ready toggling 1/0 each cycle -> identical byte order, tx_data stable while stalled, 21 transfers.
REQ-037 SHALL cover: msg_len=0 -> len_err pulse, no tx_valid, msg_count unchanged; msg_len=1 type 'S' -> bytes 0x00,0x01,0x53.
REQ-038 SHALL cover: two 'X' len-23 frames back-to-back, pl_valid=1, tx_ready=1 -> 50 consecutive tx_valid cycles, msg_count=2.
REQ-039 SHALL cover: rst low after 10 bytes of an 'A' len-36 frame -> tx_valid=0 immediately, msg_count=0, next frame starts clean with len[15:8].
REQ-040 SHALL cover: with ITCH_TX_LEN_CHECK_EN, 'A' len 30 -> len_err, 29 payload bytes drained, no output; without it, 32 bytes sent.

Source files
------------

// File: rtl/itch_tx.sv
// ITCH frame serializer: header + payload in, length-prefixed byte stream out.
// Optional ITCH 5.0 length check enabled with macro ITCH_TX_LEN_CHECK_EN.
module itch_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  msg_type,
  input  logic [15:0] msg_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_done,
  output logic        len_err,
  output logic [31:0] msg_count,
  output logic [2:0]  dbg_state
);

  // All three ports are valid/ready: a transfer happens on a rising edge where
  // valid & ready are both high; a producer holds its data stable until then.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    TYPE    = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        last_q, last_d;
  logic        tx_done_q, tx_done_d;
  logic        len_err_q, len_err_d;
  logic [31:0] msg_count_q, msg_count_d;

  logic slot_free;
  logic len_bad;

`ifdef ITCH_TX_LEN_CHECK_EN
  function automatic logic len_ok(input logic [7:0] t, input logic [15:0] l);
    logic ok;
    case (t)
      8'h53:   ok = (l == 16'd12);  // S
      8'h52:   ok = (l == 16'd39);  // R
      8'h41:   ok = (l == 16'd36);  // A
      8'h46:   ok = (l == 16'd40);  // F
      8'h45:   ok = (l == 16'd31);  // E
      8'h43:   ok = (l == 16'd36);  // C
      8'h58:   ok = (l == 16'd23);  // X
      8'h44:   ok = (l == 16'd19);  // D
      8'h55:   ok = (l == 16'd35);  // U
      8'h50:   ok = (l == 16'd44);  // P
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction
  assign len_bad = !len_ok(msg_type, msg_len);
`else
  assign len_bad = 1'b0;
`endif

  assign slot_free = !tx_valid_q || tx_ready;
  assign hdr_ready = rst && (state_q == IDLE) && slot_free;
  // DRAIN swallows payload regardless of the output slot.
  assign pl_ready  = rst && (((state_q == PAYLOAD) && slot_free) || (state_q == DRAIN));

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q && !tx_ready;
    last_d      = last_q && !tx_ready;
    tx_done_d   = tx_valid_q && tx_ready && last_q;
    len_err_d   = 1'b0;
    msg_count_d = msg_count_q + {31'd0, tx_done_d};

    case (state_q)
      IDLE: begin
        if (hdr_valid && hdr_ready) begin
          if (msg_len == 16'd0) begin
            len_err_d = 1'b1;
          end else if (len_bad) begin
            len_err_d = 1'b1;
            cnt_d     = msg_len - 16'd1;
            state_d   = (msg_len == 16'd1) ? IDLE : DRAIN;
          end else begin
            cnt_d      = msg_len - 16'd1;
            len_lo_d   = msg_len[7:0];
            type_d     = msg_type;
            tx_data_d  = msg_len[15:8];
            tx_valid_d = 1'b1;
            last_d     = 1'b0;
            state_d    = LEN_LO;
          end
        end
      end
      LEN_LO: begin
        if (slot_free) begin
          tx_data_d  = len_lo_q;
          tx_valid_d = 1'b1;
          last_d     = 1'b0;
          state_d    = TYPE;
        end
      end
      TYPE: begin
        if (slot_free) begin
          tx_data_d  = type_q;
          tx_valid_d = 1'b1;
          // A one-byte body ends with the type byte.
          last_d     = (cnt_q == 16'd0);
          state_d    = (cnt_q == 16'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pl_valid && pl_ready) begin
          tx_data_d  = pl_data;
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q - 16'd1;
          last_d     = (cnt_q == 16'd1);
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (pl_valid) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_lo_q    <= 8'd0;
      type_q      <= 8'd0;
      cnt_q       <= 16'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      last_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      len_err_q   <= 1'b0;
      msg_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      last_q      <= last_d;
      tx_done_q   <= tx_done_d;
      len_err_q   <= len_err_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_done   = tx_done_q;
  assign len_err   = len_err_q;
  assign msg_count = msg_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_itch_tx.sv
// Randomized scoreboard bench for itch_tx; expected bytes come from a frame-level model.
module tb_itch_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [7:0]  msg_type = 8'd0;
  logic [15:0] msg_len = 16'd0;
  logic [7:0]  pl_data = 8'd0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_done;
  logic        len_err;
  logic [31:0] msg_count;
  logic [2:0]  dbg_state;

  itch_tx dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .msg_type(msg_type), .msg_len(msg_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .len_err(len_err), .msg_count(msg_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0]  hdr_t_q[$];
  logic [15:0] hdr_l_q[$];
  logic [7:0]  pl_q[$];
  logic [7:0]  exp_q[$];
  bit          exp_last_q[$];

  int  rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random
  bit  pl_gaps = 1'b0;
  int  exp_frames = 0, exp_errs = 0, tot_frames = 0;
  int  done_seen = 0, err_seen = 0, xfer_cnt = 0, max_run = 0, run = 0;
  bit  stalled = 1'b0, done_due = 1'b0;
  logic [7:0] stall_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int itch_len(input logic [7:0] t);
    case (t)
      8'h53: return 12;  8'h52: return 39;  8'h41: return 36;  8'h46: return 40;
      8'h45: return 31;  8'h43: return 36;  8'h58: return 23;  8'h44: return 19;
      8'h55: return 35;  8'h50: return 44;
      default: return 0;
    endcase
  endfunction

  function automatic bit mismatch(input logic [7:0] t, input logic [15:0] l);
`ifdef ITCH_TX_LEN_CHECK_EN
    return (itch_len(t) != 0) && (int'(l) != itch_len(t));
`else
    return 1'b0;
`endif
  endfunction

  task automatic queue_frame(input logic [7:0] t, input logic [15:0] l);
    int n;
    bit bad;
    logic [7:0] b;
    hdr_t_q.push_back(t);
    hdr_l_q.push_back(l);
    if (l == 16'd0) begin
      exp_errs++;
      return;
    end
    n = int'(l) - 1;
    bad = mismatch(t, l);
    if (bad) exp_errs++;
    else begin
      exp_frames++;
      tot_frames++;
      exp_q.push_back(l[15:8]); exp_last_q.push_back(1'b0);
      exp_q.push_back(l[7:0]);  exp_last_q.push_back(1'b0);
      exp_q.push_back(t);       exp_last_q.push_back(n == 0);
    end
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      pl_q.push_back(b);
      if (!bad) begin
        exp_q.push_back(b);
        exp_last_q.push_back(i == n - 1);
      end
    end
  endtask

  // ---------------- drivers ----------------
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk); #1;
    if (rst && hdr_t_q.size() > 0) begin
      hdr_valid = 1'b1; msg_type = hdr_t_q[0]; msg_len = hdr_l_q[0];
    end else hdr_valid = 1'b0;
    #1;
    if (hdr_valid && hdr_ready) begin
      void'(hdr_t_q.pop_front());
      void'(hdr_l_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (rst && pl_q.size() > 0 && (!pl_gaps || $urandom_range(0, 3) != 0)) begin
      pl_valid = 1'b1; pl_data = pl_q[0];
    end else pl_valid = 1'b0;
    #1;
    if (pl_valid && pl_ready) void'(pl_q.pop_front());
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk); #3;
    if (!rst) begin
      stalled = 1'b0; done_due = 1'b0; run = 0;
      continue;
    end
    if (hdr_ready || pl_ready) check("hdr_pl_exclusive", hdr_ready & pl_ready, 0);
    if (tx_done || done_due) begin
      check("tx_done_timing", tx_done, done_due);
      if (done_due) check("msg_count_step", msg_count, tot_frames - exp_frames + done_seen + 1);
    end
    done_due = 1'b0;
    if (tx_done) done_seen++;
    if (len_err) err_seen++;
    if (stalled) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, stall_data);
    end
    run = tx_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (tx_valid && tx_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check("unexpected_byte", tx_data, 32'hDEAD);
      else begin
        check("tx_data", tx_data, exp_q.pop_front());
        if (exp_last_q.pop_front()) done_due = 1'b1;
      end
    end
    stalled = tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  // ---------------- scenario helpers ----------------
  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((hdr_t_q.size() > 0 || pl_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check({name, "_timeout"}, cyc < 3000, 1);
    repeat (4) @(posedge clk);
    check({name, "_done_cnt"}, done_seen, exp_frames);
    check({name, "_len_err_cnt"}, err_seen, exp_errs);
    check({name, "_msg_count"}, msg_count, tot_frames);
    done_seen = 0; err_seen = 0; exp_frames = 0; exp_errs = 0;
  endtask

  logic [7:0] types [11] = '{8'h53, 8'h52, 8'h41, 8'h46, 8'h45, 8'h43,
                             8'h58, 8'h44, 8'h55, 8'h50, 8'h5A};

  initial begin
    int base;
    int cyc;
    logic [7:0] t;
    logic [15:0] l;

    repeat (3) @(posedge clk); #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_hdr_ready", hdr_ready, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_tx_done", tx_done | len_err, 0);
    @(negedge clk); rst = 1'b1; #1;
    check("hdr_ready_after_release", hdr_ready, 1);

    // 'D' len 19, always ready
    rdy_mode = 0; base = xfer_cnt;
    queue_frame(8'h44, 16'd19);
    wait_idle("d19");
    check("d19_xfers", xfer_cnt - base, 21);

    // same frame with tx_ready toggling
    rdy_mode = 1; base = xfer_cnt;
    queue_frame(8'h44, 16'd19);
    wait_idle("d19_toggle");
    check("d19_toggle_xfers", xfer_cnt - base, 21);

    // zero length, then single-byte body
    rdy_mode = 0; base = xfer_cnt;
    queue_frame(8'h53, 16'd0);
    wait_idle("len0");
    check("len0_xfers", xfer_cnt - base, 0);
    queue_frame(8'h53, 16'd1);
    wait_idle("len1");

    // back-to-back 'X' frames
    rdy_mode = 0; pl_gaps = 1'b0;
    repeat (3) @(posedge clk);
    max_run = 0;
    queue_frame(8'h58, 16'd23);
    queue_frame(8'h58, 16'd23);
    wait_idle("b2b");
    check("b2b_run", max_run, 50);

    // randomized traffic
    rdy_mode = 2; pl_gaps = 1'b1;
    for (int i = 0; i < 12; i++) begin
      t = types[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1 && itch_len(t) != 0) l = 16'(itch_len(t));
      else l = 16'($urandom_range(0, 45));
      queue_frame(t, l);
    end
    wait_idle("random");

    // length mismatch frame: drained with the check, sent without it
    rdy_mode = 2; pl_gaps = 1'b1;
    queue_frame(8'h41, 16'd30);
    wait_idle("a30");

    // reset in the middle of an 'A' frame
    rdy_mode = 0; pl_gaps = 1'b0; base = xfer_cnt; cyc = 0;
    queue_frame(8'h41, 16'd36);
    while (xfer_cnt < base + 10 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check("midrst_reach10", cyc < 500, 1);
    #2;
    rst = 1'b0;
    hdr_t_q.delete(); hdr_l_q.delete(); pl_q.delete();
    exp_q.delete(); exp_last_q.delete();
    tot_frames = 0; exp_frames = 0; exp_errs = 0; done_seen = 0; err_seen = 0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_msg_count", msg_count, 0);
    check("midrst_hdr_ready", hdr_ready, 0);
    check("midrst_pl_ready", pl_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_hdr_ready_release", hdr_ready, 1);
    queue_frame(8'h44, 16'd19);
    wait_idle("after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
